// File: rtl/issue_alu_pipe_buffer_if.sv
// Handshake bundle between the issue stage, the ALU pipe buffer and the ALU.
// Latency: none (wires only).
// Backpressure: in_ready/out_ready valid-ready pairs; flush is a one-cycle sideband.
//
// Signals:
//   in_valid/in_ready/in_wfid/in_data     issue -> buffer push channel
//   out_valid/out_ready/out_wfid/out_data buffer -> ALU pop channel
//   flush_valid/flush_wfid                wavefront kill request
//   occupancy                             stored entries (live plus dead)
// Modports: slave = the buffer, master = the issue/ALU side (or a bench).
interface issue_alu_pipe_buffer_if #(
    parameter int DEPTH  = 4,
    parameter int WFID_W = 6,
    parameter int DATA_W = 136
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic              in_valid;
    logic              in_ready;
    logic [WFID_W-1:0] in_wfid;
    logic [DATA_W-1:0] in_data;

    logic              out_valid;
    logic              out_ready;
    logic [WFID_W-1:0] out_wfid;
    logic [DATA_W-1:0] out_data;

    logic              flush_valid;
    logic [WFID_W-1:0] flush_wfid;

    logic [OCC_W-1:0]  occupancy;

    modport slave (
        input  in_valid, in_wfid, in_data,
        output in_ready,
        output out_valid, out_wfid, out_data,
        input  out_ready,
        input  flush_valid, flush_wfid,
        output occupancy
    );

    modport master (
        output in_valid, in_wfid, in_data,
        input  in_ready,
        input  out_valid, out_wfid, out_data,
        output out_ready,
        output flush_valid, flush_wfid,
        input  occupancy
    );
endinterface

// File: rtl/issue_alu_pipe_buffer.sv
// Circular buffer between wavefront issue and the ALU, with optional per-wavefront kill.
// Latency: 1 cycle push-to-out_valid (no bypass); dead heads drain at one per cycle.
// Backpressure: in_ready = not full, from registered state only; no path from out_ready.
//
// Ports:
//   clk, rst  single clock, asynchronous active-high reset
//   bus       issue_alu_pipe_buffer_if.slave (push, pop, flush, occupancy)
// Payload packing (DATA_W=136), MSB->LSB: instr_pc[31:0], opcode[31:0],
//   imm_value0[15:0], imm_value1[31:0], dest1_addr[11:0], dest2_addr[11:0].
// Optional feature: define ISSUE_ALU_FLUSH_EN to compile in wavefront flush.
//   Without it the flush inputs are ignored and the block is a plain FIFO.
// DEPTH legal range is 2..16.
module issue_alu_pipe_buffer #(
    parameter int DEPTH  = 4,
    parameter int WFID_W = 6,
    parameter int DATA_W = 136
) (
    input  logic                  clk,
    input  logic                  rst,
    issue_alu_pipe_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Storage
    logic [WFID_W-1:0] wfid_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    // Pointers and count
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Per-entry dead flags as seen by the pop logic
    logic [DEPTH-1:0] dead;

    logic empty;
    logic full;
    logic head_dead;
    logic push_acc;
    logic flush_drop;
    logic wr_en;
    logic pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_CNT);
    assign head_dead = !empty && dead[rptr_q];

    // in_ready is a pure function of the count register, so a pop in the
    // same cycle never opens the door for a push into a full buffer.
    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty && !dead[rptr_q];
    assign bus.out_wfid  = wfid_q[rptr_q];
    assign bus.out_data  = data_q[rptr_q];
    assign bus.occupancy = count_q;

    assign push_acc = bus.in_valid && !full;
    // A dropped push still consumed in_ready; it simply never lands.
    assign wr_en    = push_acc && !flush_drop;
    // Live heads leave on the ALU handshake; dead heads leave unconditionally.
    assign pop      = (bus.out_valid && bus.out_ready) || head_dead;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;

        if (wr_en) begin
            wptr_d = (wptr_q == LAST_IDX) ? '0 : wptr_q + PTR_W'(1);
        end
        if (pop) begin
            rptr_d = (rptr_q == LAST_IDX) ? '0 : rptr_q + PTR_W'(1);
        end

        case ({wr_en, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Payload registers are reset so the head outputs never show X, even
    // while out_valid is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                wfid_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else if (wr_en) begin
            wfid_q[wptr_q] <= bus.in_wfid;
            data_q[wptr_q] <= bus.in_data;
        end
    end

`ifdef ISSUE_ALU_FLUSH_EN
    logic [DEPTH-1:0] dead_q, dead_d;

    assign dead       = dead_q;
    assign flush_drop = bus.flush_valid && (bus.in_wfid == bus.flush_wfid);

    // The flush compare runs over every slot, occupied or not. Marking a
    // free slot is harmless: a slot only becomes occupied through a write,
    // and the write clears its flag (write has the last word below).
    always_comb begin
        dead_d = dead_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (pop && (rptr_q == PTR_W'(i))) begin
                dead_d[i] = 1'b0;
            end
            if (bus.flush_valid && (wfid_q[i] == bus.flush_wfid)) begin
                dead_d[i] = 1'b1;
            end
            if (wr_en && (wptr_q == PTR_W'(i))) begin
                dead_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dead_q <= '0;
        end else begin
            dead_q <= dead_d;
        end
    end
`else
    logic unused_flush;

    assign dead         = '0;
    assign flush_drop   = 1'b0;
    assign unused_flush = ^{bus.flush_valid, bus.flush_wfid};
`endif

endmodule

// File: tb/tb_issue_alu_pipe_buffer.sv
// Self-checking bench for issue_alu_pipe_buffer against a queue-based reference model.
// Latency: model advances once per clock via tick(); outputs sampled at negedge.
// Backpressure: the model derives ready/valid from queue size and head dead flag.
module tb_issue_alu_pipe_buffer;
    localparam int DEPTH  = 4;
    localparam int WFID_W = 6;
    localparam int DATA_W = 136;
    localparam int OCC_W  = $clog2(DEPTH + 1);

    logic clk;
    logic rst;

    issue_alu_pipe_buffer_if #(.DEPTH(DEPTH), .WFID_W(WFID_W), .DATA_W(DATA_W)) bus ();

    issue_alu_pipe_buffer #(.DEPTH(DEPTH), .WFID_W(WFID_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [WFID_W-1:0] wfid;
        logic [DATA_W-1:0] data;
        bit                dead;
    } ent_t;

    ent_t mq[$];

    function automatic bit exp_in_ready();
        return mq.size() != DEPTH;
    endfunction

    function automatic bit exp_out_valid();
        if (mq.size() == 0) return 1'b0;
        return !mq[0].dead;
    endfunction

    function automatic logic [OCC_W-1:0] exp_occ();
        return OCC_W'(mq.size());
    endfunction

    function automatic logic [DATA_W-1:0] rand_data();
        logic [159:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return r[DATA_W-1:0];
    endfunction

    // Advance one clock: the model applies the inputs that are on the bus
    // now, exactly as the buffer sees them at the coming rising edge.
    task automatic tick();
        bit pop, push, drop, fl;
        logic [WFID_W-1:0] fw;
        ent_t e;
        pop  = 1'b0;
        drop = 1'b0;
        if (mq.size() != 0) pop = mq[0].dead || bus.out_ready;
        push   = bus.in_valid && (mq.size() != DEPTH);
        fl     = bus.flush_valid;
        fw     = bus.flush_wfid;
        e.wfid = bus.in_wfid;
        e.data = bus.in_data;
        e.dead = 1'b0;
`ifdef ISSUE_ALU_FLUSH_EN
        drop = fl && (e.wfid == fw);
`else
        fl = 1'b0;
`endif
        @(posedge clk);
        if (pop) mq.delete(0);
        if (fl) begin
            foreach (mq[i]) if (mq[i].wfid == fw) mq[i].dead = 1'b1;
        end
        if (push && !drop) mq.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.in_valid    = 1'b0;
        bus.in_wfid     = '0;
        bus.in_data     = '0;
        bus.out_ready   = 1'b0;
        bus.flush_valid = 1'b0;
        bus.flush_wfid  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.occupancy !== '0) begin
            n_fail++;
            $display("FAIL reset_occ_during got=%0d exp=0", bus.occupancy);
        end
        rst = 1'b0;
        mq.delete();
        @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
        end
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
        end
        n_checks++;
        if (bus.occupancy !== '0) begin
            n_fail++;
            $display("FAIL reset_occ got=%0d exp=0", bus.occupancy);
        end
        n_checks++;
        if (bus.out_data !== '0 || bus.out_wfid !== '0) begin
            n_fail++;
            $display("FAIL reset_out_payload got wfid=%0d data=%h exp 0/0", bus.out_wfid, bus.out_data);
        end
    endtask

    task automatic test_basic();
        bus.in_valid  = 1'b1;
        bus.in_wfid   = WFID_W'(3);
        bus.in_data   = DATA_W'(8'hA5);
        bus.out_ready = 1'b1;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_no_bypass got=%b exp=0", bus.out_valid);
        end
        tick();
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_wfid !== WFID_W'(3) || bus.out_data !== DATA_W'(8'hA5)) begin
            n_fail++;
            $display("FAIL basic_head got v=%b wfid=%0d data=%h exp v=1 wfid=3 data=a5",
                     bus.out_valid, bus.out_wfid, bus.out_data);
        end
        n_checks++;
        if (bus.occupancy !== OCC_W'(1)) begin
            n_fail++;
            $display("FAIL basic_occ1 got=%0d exp=1", bus.occupancy);
        end
        tick();
        n_checks++;
        if (bus.occupancy !== '0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_drained got occ=%0d v=%b exp occ=0 v=0", bus.occupancy, bus.out_valid);
        end
    endtask

    task automatic test_fill();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_wfid  = WFID_W'(10 + i);
            bus.in_data  = rand_data();
            n_checks++;
            if (bus.in_ready !== (i < DEPTH)) begin
                n_fail++;
                $display("FAIL fill_in_ready push=%0d got=%b exp=%b", i, bus.in_ready, (i < DEPTH));
            end
            tick();
        end
        n_checks++;
        if (bus.occupancy !== OCC_W'(DEPTH) || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_full got occ=%0d rdy=%b exp occ=%0d rdy=0", bus.occupancy, bus.in_ready, DEPTH);
        end
        n_checks++;
        if (bus.out_wfid !== WFID_W'(10) || bus.out_data !== mq[0].data) begin
            n_fail++;
            $display("FAIL fill_head got wfid=%0d exp=10", bus.out_wfid);
        end
    endtask

    task automatic test_full_pop_push();
        bus.in_valid  = 1'b1;
        bus.in_wfid   = WFID_W'(20);
        bus.in_data   = rand_data();
        bus.out_ready = 1'b1;
        tick();
        n_checks++;
        if (bus.occupancy !== OCC_W'(DEPTH - 1) || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL fullpp_pop_only got occ=%0d rdy=%b exp occ=%0d rdy=1", bus.occupancy, bus.in_ready, DEPTH - 1);
        end
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.occupancy !== OCC_W'(DEPTH)) begin
            n_fail++;
            $display("FAIL fullpp_push_next got occ=%0d exp=%0d", bus.occupancy, DEPTH);
        end
        bus.out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            n_checks++;
            if (bus.out_valid !== exp_out_valid() ||
                (exp_out_valid() && (bus.out_wfid !== mq[0].wfid || bus.out_data !== mq[0].data))) begin
                n_fail++;
                $display("FAIL fullpp_drain c=%0d got v=%b wfid=%0d exp v=%b", c, bus.out_valid, bus.out_wfid, exp_out_valid());
            end
            tick();
        end
        n_checks++;
        if (bus.occupancy !== '0 || mq.size() != 0) begin
            n_fail++;
            $display("FAIL fullpp_empty got occ=%0d exp=0", bus.occupancy);
        end
    endtask

    task automatic test_flush();
        int wl[4] = '{1, 2, 1, 4};
        int seen[$];
        int exp_seen[$];
        bit saw_two;
`ifdef ISSUE_ALU_FLUSH_EN
        exp_seen = '{2, 4};
`else
        exp_seen = '{1, 2, 1, 4};
`endif
        saw_two = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_wfid  = WFID_W'(wl[i]);
            bus.in_data  = DATA_W'(32'hF000 + i);
            tick();
        end
        bus.in_valid    = 1'b0;
        bus.flush_valid = 1'b1;
        bus.flush_wfid  = WFID_W'(1);
        tick();
        bus.flush_valid = 1'b0;
        bus.out_ready   = 1'b1;
        for (int c = 0; c < 10; c++) begin
            n_checks++;
            if (bus.out_valid !== exp_out_valid() || bus.occupancy !== exp_occ() ||
                (exp_out_valid() && bus.out_wfid !== mq[0].wfid)) begin
                n_fail++;
                $display("FAIL flush_cycle c=%0d got v=%b occ=%0d exp v=%b occ=%0d",
                         c, bus.out_valid, bus.occupancy, exp_out_valid(), exp_occ());
            end
            if (bus.occupancy == OCC_W'(2)) saw_two = 1'b1;
            if (bus.out_valid === 1'b1) seen.push_back(int'(bus.out_wfid));
            tick();
        end
        n_checks++;
        if (seen != exp_seen) begin
            n_fail++;
            $display("FAIL flush_order got n=%0d exp n=%0d", seen.size(), exp_seen.size());
        end
        n_checks++;
        if (!saw_two || bus.occupancy !== '0) begin
            n_fail++;
            $display("FAIL flush_occ got saw2=%b final=%0d exp saw2=1 final=0", saw_two, bus.occupancy);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        int delivered;
        logic [DATA_W-1:0] first_dat;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_wfid  = WFID_W'(30 + i);
            bus.in_data  = rand_data();
            tick();
        end
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.occupancy !== '0) begin
            n_fail++;
            $display("FAIL arst_immediate got v=%b occ=%0d exp v=0 occ=0", bus.out_valid, bus.occupancy);
        end
        n_checks++;
        if (bus.out_data !== '0 || bus.out_wfid !== '0) begin
            n_fail++;
            $display("FAIL arst_payload got wfid=%0d exp 0", bus.out_wfid);
        end
        #1 rst = 1'b0;
        mq.delete();
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.occupancy !== '0) begin
            n_fail++;
            $display("FAIL arst_after got v=%b occ=%0d exp v=0 occ=0", bus.out_valid, bus.occupancy);
        end
        delivered     = 0;
        first_dat     = rand_data();
        bus.out_ready = 1'b1;
        for (int c = 0; c < 2 * DEPTH + 3; c++) begin
            bus.in_valid = (c < 2 * DEPTH);
            bus.in_wfid  = WFID_W'(c);
            bus.in_data  = (c == 0) ? first_dat : rand_data();
            n_checks++;
            if (bus.out_valid !== exp_out_valid() || bus.occupancy !== exp_occ() ||
                (exp_out_valid() && (bus.out_wfid !== mq[0].wfid || bus.out_data !== mq[0].data))) begin
                n_fail++;
                $display("FAIL arst_wrap c=%0d got v=%b wfid=%0d exp v=%b", c, bus.out_valid, bus.out_wfid, exp_out_valid());
            end
            if (bus.out_valid === 1'b1) begin
                if (delivered == 0) begin
                    n_checks++;
                    if (bus.out_data !== first_dat) begin
                        n_fail++;
                        $display("FAIL arst_first_data got=%h exp=%h", bus.out_data, first_dat);
                    end
                end
                delivered++;
            end
            tick();
        end
        n_checks++;
        if (delivered != 2 * DEPTH) begin
            n_fail++;
            $display("FAIL arst_count got=%0d exp=%0d", delivered, 2 * DEPTH);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bus.in_valid    = ($urandom_range(0, 3) != 0);
            bus.in_wfid     = WFID_W'($urandom_range(0, 3));
            bus.in_data     = rand_data();
            bus.out_ready   = ($urandom_range(0, 2) != 0);
            bus.flush_valid = ($urandom_range(0, 7) == 0);
            bus.flush_wfid  = WFID_W'($urandom_range(0, 3));
            n_checks++;
            if (bus.in_ready !== exp_in_ready()) begin
                n_fail++;
                $display("FAIL rnd_in_ready c=%0d got=%b exp=%b", c, bus.in_ready, exp_in_ready());
            end
            n_checks++;
            if (bus.out_valid !== exp_out_valid()) begin
                n_fail++;
                $display("FAIL rnd_out_valid c=%0d got=%b exp=%b", c, bus.out_valid, exp_out_valid());
            end
            n_checks++;
            if (bus.occupancy !== exp_occ()) begin
                n_fail++;
                $display("FAIL rnd_occ c=%0d got=%0d exp=%0d", c, bus.occupancy, exp_occ());
            end
            if (exp_out_valid()) begin
                n_checks++;
                if (bus.out_wfid !== mq[0].wfid || bus.out_data !== mq[0].data) begin
                    n_fail++;
                    $display("FAIL rnd_head c=%0d got wfid=%0d exp wfid=%0d", c, bus.out_wfid, mq[0].wfid);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_full_pop_push();
        test_flush();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
